// File: rtl/mem_stage.sv
// MIPS32 memory stage: EX/MEM register, valid/ready data-memory access,
// upstream stall generation, MEM/WB register and M-stage forwarding.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_out_e,
  input  logic [DATA_W-1:0] write_data_e,
  input  logic [REG_W-1:0]  write_reg_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              mem_write_e,
  output logic              mem_stall,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [DATA_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_rdata,
  output logic              fwd_en_m,
  output logic [REG_W-1:0]  fwd_reg_m,
  output logic [DATA_W-1:0] fwd_val_m,
  output logic [DATA_W-1:0] result_w,
  output logic [REG_W-1:0]  write_reg_w,
  output logic              reg_write_w,
  output logic              mem_err_w
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;

  logic [DATA_W-1:0] alu_out_m_q, alu_out_m_d;
  logic [DATA_W-1:0] write_data_m_q, write_data_m_d;
  logic [REG_W-1:0]  write_reg_m_q, write_reg_m_d;
  logic              reg_write_m_q, reg_write_m_d;
  logic              mem_to_reg_m_q, mem_to_reg_m_d;
  logic              mem_write_m_q, mem_write_m_d;

  logic [DATA_W-1:0] result_w_q, result_w_d;
  logic [REG_W-1:0]  write_reg_w_q, write_reg_w_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic              mem_err_w_q, mem_err_w_d;

  logic              is_load_m, is_store_m, misaligned_m, issue_e;

  // Op classification; a load+store encoding is treated as a load.
  always_comb begin
    is_load_m    = mem_to_reg_m_q;
    is_store_m   = mem_write_m_q & ~mem_to_reg_m_q;
    misaligned_m = (mem_to_reg_m_q | mem_write_m_q) && (alu_out_m_q[1:0] != 2'b00);
    issue_e      = (mem_to_reg_e | mem_write_e) && (alu_out_e[1:0] == 2'b00);
  end

  // Stall while a request is unaccepted or a load response is outstanding.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      S_ISSUE: mem_stall = !(dmem_req_ready && (is_store_m || dmem_resp_valid));
      S_WAIT:  mem_stall = !dmem_resp_valid;
      default: mem_stall = 1'b0;
    endcase
  end

  // Next-state for FSM, M register and W register.
  always_comb begin
    state_d        = state_q;
    alu_out_m_d    = alu_out_m_q;
    write_data_m_d = write_data_m_q;
    write_reg_m_d  = write_reg_m_q;
    reg_write_m_d  = reg_write_m_q;
    mem_to_reg_m_d = mem_to_reg_m_q;
    mem_write_m_d  = mem_write_m_q;
    result_w_d     = result_w_q;
    write_reg_w_d  = write_reg_w_q;
    reg_write_w_d  = 1'b0;
    mem_err_w_d    = 1'b0;
    if (!mem_stall) begin
      // Completion cycle doubles as the capture cycle, so back-to-back
      // mem ops go straight from completion into ISSUE.
      alu_out_m_d    = alu_out_e;
      write_data_m_d = write_data_e;
      write_reg_m_d  = write_reg_e;
      reg_write_m_d  = reg_write_e;
      mem_to_reg_m_d = mem_to_reg_e;
      mem_write_m_d  = mem_write_e;
      state_d        = issue_e ? S_ISSUE : S_IDLE;
      write_reg_w_d  = write_reg_m_q;
      reg_write_w_d  = reg_write_m_q && !misaligned_m;
      mem_err_w_d    = misaligned_m;
      result_w_d     = is_load_m ? dmem_resp_rdata : alu_out_m_q;
    end else if (state_q == S_ISSUE && dmem_req_ready) begin
      state_d = S_WAIT;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      alu_out_m_q    <= '0;
      write_data_m_q <= '0;
      write_reg_m_q  <= '0;
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_w_q     <= '0;
      write_reg_w_q  <= '0;
      reg_write_w_q  <= 1'b0;
      mem_err_w_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_out_m_q    <= alu_out_m_d;
      write_data_m_q <= write_data_m_d;
      write_reg_m_q  <= write_reg_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_w_q     <= result_w_d;
      write_reg_w_q  <= write_reg_w_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_err_w_q    <= mem_err_w_d;
    end
  end

  // Output mapping: bus, forwarding and writeback.
  always_comb begin
    dmem_req_valid = (state_q == S_ISSUE);
    dmem_req_we    = is_store_m;
    dmem_req_addr  = alu_out_m_q;
    dmem_req_wdata = write_data_m_q;
    fwd_en_m       = reg_write_m_q && !mem_to_reg_m_q && (write_reg_m_q != '0);
    fwd_reg_m      = write_reg_m_q;
    fwd_val_m      = alu_out_m_q;
    result_w       = result_w_q;
    write_reg_w    = write_reg_w_q;
    reg_write_w    = reg_write_w_q;
    mem_err_w      = mem_err_w_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected bus requests and writebacks are
// queued at issue time and consumed by an independent negedge monitor.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out_e, write_data_e;
  logic [4:0]  write_reg_e;
  logic        reg_write_e, mem_to_reg_e, mem_write_e;
  logic        mem_stall;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        fwd_en_m;
  logic [4:0]  fwd_reg_m;
  logic [31:0] fwd_val_m, result_w;
  logic [4:0]  write_reg_w;
  logic        reg_write_w, mem_err_w;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  bus_t bus_exp;
  wb_t  wb_exp;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .mem_stall(mem_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .fwd_en_m(fwd_en_m), .fwd_reg_m(fwd_reg_m), .fwd_val_m(fwd_val_m),
    .result_w(result_w), .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .mem_err_w(mem_err_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic st);
    alu_out_e    = a;
    write_data_e = wd;
    write_reg_e  = rd;
    reg_write_e  = rw;
    mem_to_reg_e = ld;
    mem_write_e  = st;
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus_t b;
    b.we = we; b.addr = a; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic push_wb(input logic [31:0] r, input logic [4:0] rd, input logic rw, input logic err);
    wb_t w;
    w.result = r; w.rd = rd; w.rw = rw; w.err = err;
    wb_q.push_back(w);
  endtask

  // Monitor: every accepted request and every retirement must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      if (dmem_req_valid && dmem_req_ready) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected", 32'd1, 32'd0);
        end else begin
          bus_exp = bus_q.pop_front();
          check("bus_we", {31'd0, dmem_req_we}, {31'd0, bus_exp.we});
          check("bus_addr", dmem_req_addr, bus_exp.addr);
          if (bus_exp.we) check("bus_wdata", dmem_req_wdata, bus_exp.wdata);
        end
      end
      if (reg_write_w || mem_err_w) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          wb_exp = wb_q.pop_front();
          check("wb_rd", {27'd0, write_reg_w}, {27'd0, wb_exp.rd});
          check("wb_rw", {31'd0, reg_write_w}, {31'd0, wb_exp.rw});
          check("wb_err", {31'd0, mem_err_w}, {31'd0, wb_exp.err});
          if (wb_exp.rw) check("wb_result", result_w, wb_exp.result);
        end
      end
    end
  end

  int stall_cnt;

  initial begin
    rst = 1'b0;
    set_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'd0;
    #3;
    check("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
    check("rst_result_w", result_w, 32'd0);
    check("rst_fwd_en", {31'd0, fwd_en_m}, 32'd0);
    check("rst_mem_err", {31'd0, mem_err_w}, 32'd0);
    tick(); tick();
    rst = 1'b1;

    // ALU op, then a write to $0 back-to-back
    set_e(32'h1234, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    push_wb(32'h1234, 5'd8, 1'b1, 1'b0);
    tick();
    check("alu_fwd_en", {31'd0, fwd_en_m}, 32'd1);
    check("alu_fwd_reg", {27'd0, fwd_reg_m}, 32'd8);
    check("alu_fwd_val", fwd_val_m, 32'h1234);
    check("alu_stall", {31'd0, mem_stall}, 32'd0);
    set_e(32'h77, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    push_wb(32'h77, 5'd0, 1'b1, 1'b0);
    tick();
    check("alu_result_w", result_w, 32'h1234);
    check("alu_reg_write_w", {31'd0, reg_write_w}, 32'd1);
    check("r0_fwd_en", {31'd0, fwd_en_m}, 32'd0);
    check("r0_fwd_val", fwd_val_m, 32'h77);
    set_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("r0_reg_write_w", {31'd0, reg_write_w}, 32'd1);
    tick();

    // Store with 3 cycles of backpressure
    set_e(32'h100, 32'hDEADBEEF, 5'd3, 1'b0, 1'b0, 1'b1);
    push_bus(1'b1, 32'h100, 32'hDEADBEEF);
    tick();
    set_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_req_ready = (i == 3);
      #1;
      check("st_valid", {31'd0, dmem_req_valid}, 32'd1);
      check("st_we", {31'd0, dmem_req_we}, 32'd1);
      check("st_addr", dmem_req_addr, 32'h100);
      check("st_wdata", dmem_req_wdata, 32'hDEADBEEF);
      if (mem_stall) stall_cnt++;
      check("st_reg_write_w", {31'd0, reg_write_w}, 32'd0);
      tick();
    end
    check("st_stall_cycles", stall_cnt, 32'd3);
    dmem_req_ready = 1'b0;
    #1;
    check("st_valid_done", {31'd0, dmem_req_valid}, 32'd0);
    tick();

    // Load with immediate accept and response two cycles later
    set_e(32'h40, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    dmem_req_ready = 1'b1;
    push_bus(1'b0, 32'h40, 32'd0);
    push_wb(32'hCAFEF00D, 5'd9, 1'b1, 1'b0);
    tick();
    set_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("ld_issue_valid", {31'd0, dmem_req_valid}, 32'd1);
    check("ld_issue_stall", {31'd0, mem_stall}, 32'd1);
    check("ld_fwd_en", {31'd0, fwd_en_m}, 32'd0);
    tick();
    dmem_req_ready = 1'b0;
    #1;
    check("ld_wait_valid", {31'd0, dmem_req_valid}, 32'd0);
    check("ld_wait_stall", {31'd0, mem_stall}, 32'd1);
    check("ld_wait_bubble", {31'd0, reg_write_w}, 32'd0);
    check("ld_wait_fwd_en", {31'd0, fwd_en_m}, 32'd0);
    tick();
    check("ld_wait2_stall", {31'd0, mem_stall}, 32'd1);
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'hCAFEF00D;
    #1;
    check("ld_resp_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'd0;
    check("ld_result_w", result_w, 32'hCAFEF00D);
    check("ld_write_reg_w", {27'd0, write_reg_w}, 32'd9);
    check("ld_reg_write_w", {31'd0, reg_write_w}, 32'd1);
    tick();

    // Zero-latency load followed back-to-back by a store
    set_e(32'h80, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0);
    dmem_req_ready = 1'b1;
    push_bus(1'b0, 32'h80, 32'd0);
    push_wb(32'h11112222, 5'd10, 1'b1, 1'b0);
    tick();
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'h11112222;
    set_e(32'h84, 32'h55AA55AA, 5'd0, 1'b0, 1'b0, 1'b1);
    push_bus(1'b1, 32'h84, 32'h55AA55AA);
    #1;
    check("zl_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'd0;
    set_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("zl_result_w", result_w, 32'h11112222);
    check("b2b_valid", {31'd0, dmem_req_valid}, 32'd1);
    check("b2b_we", {31'd0, dmem_req_we}, 32'd1);
    check("b2b_addr", dmem_req_addr, 32'h84);
    check("b2b_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_req_ready = 1'b0;
    #1;
    check("b2b_valid_done", {31'd0, dmem_req_valid}, 32'd0);
    tick();

    // Misaligned load: ready held high so any stray request would be seen
    dmem_req_ready = 1'b1;
    set_e(32'h102, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0);
    push_wb(32'd0, 5'd11, 1'b0, 1'b1);
    tick();
    set_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("mis_valid", {31'd0, dmem_req_valid}, 32'd0);
    check("mis_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("mis_err", {31'd0, mem_err_w}, 32'd1);
    check("mis_reg_write_w", {31'd0, reg_write_w}, 32'd0);
    tick();
    check("mis_err_pulse", {31'd0, mem_err_w}, 32'd0);
    dmem_req_ready = 1'b0;
    tick();

    // Reset during WAIT_RESP, then a late response
    set_e(32'hC0, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0);
    push_bus(1'b0, 32'hC0, 32'd0);
    tick();
    set_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    #1;
    check("rw_wait_stall", {31'd0, mem_stall}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rw_rst_valid", {31'd0, dmem_req_valid}, 32'd0);
    check("rw_rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rw_rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'hBAD0BAD0;
    #1;
    check("late_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'd0;
    check("late_reg_write_w", {31'd0, reg_write_w}, 32'd0);
    check("late_result_w", result_w, 32'd0);
    tick();

    // Reset while a request is still presented in ISSUE
    set_e(32'hD0, 32'd0, 5'd13, 1'b1, 1'b1, 1'b0);
    tick();
    set_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("ri_valid", {31'd0, dmem_req_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("ri_rst_valid", {31'd0, dmem_req_valid}, 32'd0);
    check("ri_rst_stall", {31'd0, mem_stall}, 32'd0);
    check("ri_rst_fwd_val", fwd_val_m, 32'd0);
    tick();
    rst = 1'b1;
    tick(); tick();

    check("bus_q_empty", bus_q.size(), 32'd0);
    check("wb_q_empty", wb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
